// File: rtl/tlb_asid_if.sv
// rtl/tlb_asid_if.sv - TLB lookup, refill and sfence.vma flush bus
interface tlb_asid_if #(
    parameter int VPN_W  = 20,
    parameter int PTE_W  = 64,
    parameter int ASID_W = 9,
    parameter int XLEN   = 32
);
    logic              cs;
    logic              we;
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic              spage;
    logic              global_in;
    logic [PTE_W-1:0]  pte_in;
    logic              pte_hit;
    logic [PTE_W-1:0]  pte_out;
    logic              busy;
    logic              tlb_flush_req;
    logic              tlb_flush_all_vaddr;
    logic              tlb_flush_all_asid;
    logic [XLEN-1:0]   tlb_flush_vaddr;
    logic [XLEN-1:0]   tlb_flush_asid;

    modport master (
        output cs, we, vpn, asid, spage, global_in, pte_in,
               tlb_flush_req, tlb_flush_all_vaddr, tlb_flush_all_asid,
               tlb_flush_vaddr, tlb_flush_asid,
        input  pte_hit, pte_out, busy
    );

    modport slave (
        input  cs, we, vpn, asid, spage, global_in, pte_in,
               tlb_flush_req, tlb_flush_all_vaddr, tlb_flush_all_asid,
               tlb_flush_vaddr, tlb_flush_asid,
        output pte_hit, pte_out, busy
    );
endinterface

// File: rtl/tlb_asid.sv
// rtl/tlb_asid.sv - set-associative TLB with true-LRU and selective flushing
// Define TLB_ASID_EN for ASID tags, global entries and the ASID-only sweep flush.
module tlb_asid #(
    parameter int WAYS   = 4,
    parameter int SETS   = 32,
    parameter int VPN_W  = 20,
    parameter int PTE_W  = 64,
    parameter int ASID_W = 9,
    parameter int XLEN   = 32
) (
    input  logic       clk,
    input  logic       rstn,
    tlb_asid_if.slave  bus
);
    localparam int IW = $clog2(SETS);
    localparam int AW = $clog2(WAYS);
    localparam int TW = VPN_W - IW;

    logic             valid_q [SETS][WAYS];
    logic             spg_q   [SETS][WAYS];
    logic [TW-1:0]    tag_q   [SETS][WAYS];
    logic [PTE_W-1:0] pte_q   [SETS][WAYS];
    logic [AW-1:0]    age_q   [SETS][WAYS];
    logic             pte_hit_q;
    logic [PTE_W-1:0] pte_out_q;

    function automatic logic [TW-1:0] mk_tag(input logic [VPN_W-1:0] v, input logic sp);
        return {v[VPN_W-1:10+IW], sp ? 10'd0 : v[9:0]};
    endfunction

    // Superpage tags are stored with VPN0 zeroed, so their VPN0 field is skipped.
    function automatic logic tag_hit(input logic [TW-1:0] t, input logic sp, input logic [VPN_W-1:0] v);
        return (t[TW-1:10] == v[VPN_W-1:10+IW]) && (sp || t[9:0] == v[9:0]);
    endfunction

    logic [IW-1:0]    idx, fidx;
    logic [VPN_W-1:0] fvpn;
    logic [TW-1:0]    rtag;
    logic             busy_i, flush_acc, flush_all, flush_va;
    logic             unused;

    assign idx  = bus.vpn[10 +: IW];
    assign fvpn = bus.tlb_flush_vaddr[12 +: VPN_W];
    assign fidx = fvpn[10 +: IW];
    assign rtag = mk_tag(bus.vpn, bus.spage);

`ifdef TLB_ASID_EN
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t            state_q;
    logic [IW-1:0]     ptr_q;
    logic [ASID_W-1:0] fasid_q, fasid;
    logic              glb_q  [SETS][WAYS];
    logic [ASID_W-1:0] asid_q [SETS][WAYS];
    logic [WAYS-1:0]   sclr;

    assign fasid     = bus.tlb_flush_asid[ASID_W-1:0];
    assign busy_i    = (state_q == SWEEP);
    assign flush_acc = bus.tlb_flush_req && !busy_i;
    assign flush_all = bus.tlb_flush_all_vaddr && bus.tlb_flush_all_asid;
    assign flush_va  = !bus.tlb_flush_all_vaddr;
    assign unused    = &{1'b0, bus.tlb_flush_vaddr[11:0], bus.tlb_flush_asid[XLEN-1:ASID_W]};
`else
    assign busy_i    = 1'b0;
    assign flush_acc = bus.tlb_flush_req;
    assign flush_all = bus.tlb_flush_all_vaddr;
    assign flush_va  = !bus.tlb_flush_all_vaddr;
    assign unused    = &{1'b0, bus.asid, bus.global_in, bus.tlb_flush_all_asid,
                         bus.tlb_flush_asid, bus.tlb_flush_vaddr[11:0]};
`endif

    logic [WAYS-1:0] fclr;
    logic            hit_any, dup_any, inv_any, touch;
    logic [AW-1:0]   hit_way, dup_way, inv_way, old_way, wr_way, tw;

    always_comb begin
        logic h, d;
        fclr = '0;
        hit_any = 1'b0; dup_any = 1'b0; inv_any = 1'b0;
        hit_way = '0;   dup_way = '0;   inv_way = '0;   old_way = '0;
`ifdef TLB_ASID_EN
        sclr = '0;
`endif
        // Descending scan so the lowest-index candidate wins each priority.
        for (int g = WAYS-1; g >= 0; g--) begin
            h = valid_q[idx][g] && tag_hit(tag_q[idx][g], spg_q[idx][g], bus.vpn);
            d = valid_q[idx][g] && (tag_q[idx][g] == rtag);
            fclr[g] = valid_q[fidx][g] && tag_hit(tag_q[fidx][g], spg_q[fidx][g], fvpn);
`ifdef TLB_ASID_EN
            h = h && (glb_q[idx][g] || asid_q[idx][g] == bus.asid);
            d = d && (asid_q[idx][g] == bus.asid);
            fclr[g] = fclr[g] && (bus.tlb_flush_all_asid ||
                                  (!glb_q[fidx][g] && asid_q[fidx][g] == fasid));
            sclr[g] = !glb_q[ptr_q][g] && (asid_q[ptr_q][g] == fasid_q);
`endif
            if (h) begin hit_any = 1'b1; hit_way = AW'(g); end
            if (d) begin dup_any = 1'b1; dup_way = AW'(g); end
            if (!valid_q[idx][g]) begin inv_any = 1'b1; inv_way = AW'(g); end
            if (age_q[idx][g] == AW'(WAYS-1)) old_way = AW'(g);
        end
        wr_way = dup_any ? dup_way : (inv_any ? inv_way : old_way);
    end

    assign touch = !flush_acc && !busy_i && bus.cs && (bus.we || hit_any);
    assign tw    = bus.we ? wr_way : hit_way;

    logic [PTE_W-1:0] hit_pte, raw_pte;
    assign raw_pte = pte_q[idx][hit_way];
    assign hit_pte = spg_q[idx][hit_way] ? {raw_pte[PTE_W-1:20], bus.vpn[9:0], raw_pte[9:0]} : raw_pte;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SETS; s++) begin
                for (int g = 0; g < WAYS; g++) begin
                    valid_q[s][g] <= 1'b0;
                    spg_q[s][g]   <= 1'b0;
                    tag_q[s][g]   <= '0;
                    pte_q[s][g]   <= '0;
                    age_q[s][g]   <= AW'(g);
`ifdef TLB_ASID_EN
                    glb_q[s][g]   <= 1'b0;
                    asid_q[s][g]  <= '0;
`endif
                end
            end
            pte_hit_q <= 1'b0;
            pte_out_q <= '0;
`ifdef TLB_ASID_EN
            state_q <= IDLE;
            ptr_q   <= '0;
            fasid_q <= '0;
`endif
        end else begin
            if (flush_acc || busy_i) begin
                if (bus.cs && !bus.we) begin
                    pte_hit_q <= 1'b0;
                    pte_out_q <= '0;
                end
            end else if (bus.cs) begin
                if (bus.we) begin
                    valid_q[idx][wr_way] <= 1'b1;
                    spg_q[idx][wr_way]   <= bus.spage;
                    tag_q[idx][wr_way]   <= rtag;
                    pte_q[idx][wr_way]   <= bus.pte_in;
`ifdef TLB_ASID_EN
                    glb_q[idx][wr_way]   <= bus.global_in;
                    asid_q[idx][wr_way]  <= bus.asid;
`endif
                end else begin
                    pte_hit_q <= hit_any;
                    pte_out_q <= hit_any ? hit_pte : '0;
                end
            end
            if (touch) begin
                for (int g = 0; g < WAYS; g++) begin
                    if (AW'(g) == tw)
                        age_q[idx][g] <= '0;
                    else if (age_q[idx][g] < age_q[idx][tw])
                        age_q[idx][g] <= age_q[idx][g] + 1'b1;
                end
            end
            if (flush_acc) begin
                if (flush_all) begin
                    for (int s = 0; s < SETS; s++)
                        for (int g = 0; g < WAYS; g++)
                            valid_q[s][g] <= 1'b0;
                end else if (flush_va) begin
                    for (int g = 0; g < WAYS; g++)
                        if (fclr[g]) valid_q[fidx][g] <= 1'b0;
                end
`ifdef TLB_ASID_EN
                else begin
                    state_q <= SWEEP;
                    ptr_q   <= '0;
                    fasid_q <= fasid;
                end
`endif
            end
`ifdef TLB_ASID_EN
            if (state_q == SWEEP) begin
                for (int g = 0; g < WAYS; g++)
                    if (sclr[g]) valid_q[ptr_q][g] <= 1'b0;
                ptr_q <= ptr_q + 1'b1;
                if (ptr_q == IW'(SETS-1)) state_q <= IDLE;
            end
`endif
        end
    end

    assign bus.pte_hit = pte_hit_q;
    assign bus.pte_out = pte_out_q;
    assign bus.busy    = busy_i;
endmodule

// File: tb/tb_tlb_asid.sv
// tb/tb_tlb_asid.sv - scoreboard bench for tlb_asid (expectations follow TLB_ASID_EN)
module tb_tlb_asid;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

`ifdef TLB_ASID_EN
    localparam bit ASID_ON = 1'b1;
`else
    localparam bit ASID_ON = 1'b0;
`endif

    tlb_asid_if bus ();
    tlb_asid dut (.clk(clk), .rstn(rstn), .bus(bus));

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    logic [64:0] sb [$];
    logic [64:0] exp_e;
    logic        lk_d;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk or negedge rstn)
        if (!rstn) lk_d <= 1'b0;
        else       lk_d <= bus.cs && !bus.we;

    always @(negedge clk) begin
        if (bus.busy) busy_cycles++;
        if (lk_d) begin
            if (sb.size() == 0) check("sb_underrun", 64'd1, 64'd0);
            else begin
                exp_e = sb.pop_front();
                check("pte_hit", 64'(bus.pte_hit), 64'(exp_e[64]));
                if (exp_e[64]) check("pte_out", bus.pte_out, exp_e[63:0]);
            end
        end
    end

    task automatic cyc(input bit c, input bit w, input logic [19:0] v, input logic [8:0] a,
                       input bit sp, input bit gl, input logic [63:0] p,
                       input bit fr, input bit fav, input bit faa,
                       input logic [31:0] fva, input logic [31:0] fas,
                       input bit eh, input logic [63:0] ep);
        @(negedge clk);
        bus.cs = c; bus.we = w; bus.vpn = v; bus.asid = a;
        bus.spage = sp; bus.global_in = gl; bus.pte_in = p;
        bus.tlb_flush_req = fr; bus.tlb_flush_all_vaddr = fav; bus.tlb_flush_all_asid = faa;
        bus.tlb_flush_vaddr = fva; bus.tlb_flush_asid = fas;
        if (c && !w) sb.push_back({eh, ep});
    endtask

    task automatic refill(input logic [19:0] v, input logic [8:0] a, input bit sp, input bit gl,
                          input logic [63:0] p);
        cyc(1, 1, v, a, sp, gl, p, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input logic [19:0] v, input logic [8:0] a, input bit eh, input logic [63:0] ep);
        cyc(1, 0, v, a, 0, 0, 0, 0, 0, 0, 0, 0, eh, ep);
    endtask

    task automatic flush(input bit fav, input bit faa, input logic [31:0] fva, input logic [31:0] fas);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, fav, faa, fva, fas, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cs = 0; bus.we = 0; bus.vpn = 0; bus.asid = 0; bus.spage = 0; bus.global_in = 0;
        bus.pte_in = 0; bus.tlb_flush_req = 0; bus.tlb_flush_all_vaddr = 0;
        bus.tlb_flush_all_asid = 0; bus.tlb_flush_vaddr = 0; bus.tlb_flush_asid = 0;
        repeat (2) @(negedge clk);
        check("rst_hit", 64'(bus.pte_hit), 0);
        check("rst_pte", bus.pte_out, 0);
        check("rst_busy", 64'(bus.busy), 0);
        rstn = 1'b1;
        lookup(20'h12345, 3, 0, 0);

        // basic refill / ASID tagging / output hold across a write
        refill(20'h12345, 3, 0, 0, 64'hABCD);
        lookup(20'h12345, 3, 1, 64'hABCD);
        lookup(20'h12345, 4, !ASID_ON, 64'hABCD);
        lookup(20'h12346, 3, 0, 0);
        lookup(20'h12345, 3, 1, 64'hABCD);
        refill(20'h12346, 3, 0, 0, 64'h1111);
        idle(1);
        check("hold_hit", 64'(bus.pte_hit), 1);
        check("hold_pte", bus.pte_out, 64'hABCD);

        // vaddr flush, then flush colliding with refill and with lookup
        flush(0, 1, 32'h1234_5000, 0);
        lookup(20'h12345, 3, 0, 0);
        lookup(20'h12346, 3, 1, 64'h1111);
        cyc(1, 1, 20'h22222, 3, 0, 0, 64'h2222, 1, 0, 1, 32'h9999_9000, 0, 0, 0);
        lookup(20'h22222, 3, 0, 0);
        cyc(1, 0, 20'h12346, 3, 0, 0, 0, 1, 0, 1, 32'h9999_9000, 0, 0, 0);
        lookup(20'h12346, 3, 1, 64'h1111);

        // flush all
        flush(1, 1, 0, 0);
        idle(1);
        check("fa_busy", 64'(bus.busy), 0);
        lookup(20'h12346, 3, 0, 0);

        // superpage
        refill(20'h12000, 3, 1, 0, 64'h2000_0000);
        lookup(20'h12155, 3, 1, 64'h2005_5400);
        lookup(20'h12000, 3, 1, 64'h2000_0000);
        lookup(20'h13155, 3, 0, 0);

        // LRU: five tags into set 3, first tag touched after the second fill
        flush(1, 1, 0, 0);
        refill(20'h08C00, 3, 0, 0, 64'hA1);
        refill(20'h10C00, 3, 0, 0, 64'hA2);
        lookup(20'h08C00, 3, 1, 64'hA1);
        refill(20'h18C00, 3, 0, 0, 64'hA3);
        refill(20'h20C00, 3, 0, 0, 64'hA4);
        refill(20'h28C00, 3, 0, 0, 64'hA5);
        lookup(20'h08C00, 3, 1, 64'hA1);
        lookup(20'h18C00, 3, 1, 64'hA3);
        lookup(20'h20C00, 3, 1, 64'hA4);
        lookup(20'h28C00, 3, 1, 64'hA5);
        lookup(20'h10C00, 3, 0, 0);

        // ASID-only flush sweep
        flush(1, 1, 0, 0);
        refill(20'h00400, 3, 0, 0, 64'h31);
        refill(20'h08400, 5, 0, 0, 64'h55);
        refill(20'h07C00, 3, 0, 0, 64'h32);
        refill(20'h00800, 3, 0, 1, 64'h47);
        lookup(20'h00800, 7, 1, 64'h47);
        lookup(20'h08400, 5, 1, 64'h55);
        busy_cycles = 0;
        flush(1, 0, 0, 3);
        for (int i = 0; i < 32; i++)
            cyc(1, 0, 20'h00800, 3, 0, 0, 0, (i == 5), 1, 1, 0, 0, 0, 0);
        idle(1);
        check("sweep_cycles", 64'(busy_cycles), ASID_ON ? 64'd32 : 64'd0);
        check("sweep_done", 64'(bus.busy), 0);
        lookup(20'h00400, 3, 0, 0);
        lookup(20'h07C00, 3, 0, 0);
        lookup(20'h00800, 3, ASID_ON, 64'h47);
        lookup(20'h08400, 5, ASID_ON, 64'h55);

        // reset in the middle of a sweep
        refill(20'h08400, 5, 0, 0, 64'h55);
        lookup(20'h08400, 5, 1, 64'h55);
        flush(1, 0, 0, 9);
        idle(10);
        check("mid_busy", 64'(bus.busy), 64'(ASID_ON));
        check("pre_rst_hit", 64'(bus.pte_hit), 1);
        rstn = 1'b0;
        #1;
        check("rst2_busy", 64'(bus.busy), 0);
        check("rst2_hit", 64'(bus.pte_hit), 0);
        check("rst2_pte", bus.pte_out, 0);
        for (int g = 0; g < 4; g++) check("rst2_age", 64'(dut.age_q[3][g]), 64'(g));
        @(negedge clk);
        rstn = 1'b1;
        lookup(20'h08400, 5, 0, 0);
        lookup(20'h00800, 3, 0, 0);
        lookup(20'h28C00, 3, 0, 0);
        idle(2);
        check("sb_drain", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tlb_asid.md
# tlb_asid

Parametrised set-associative TLB with ASID-tagged entries, a global bit, true-LRU replacement and selective `sfence.vma`-style flushing. It sits between the MMU page-table walker and the instruction/data address-translation path. The core looks up a VPN plus the current ASID, and the walker refills on a miss. Selective flushes by vaddr, by ASID, or both are handled in hardware; the ASID-only case uses a multi-cycle set sweep.

## Interface
- `WAYS`, 4: associativity; power of two, ≥2.
- `SETS`, 32: sets per way; power of two, ≥2.
- `VPN_W`, 20: VPN width (Sv32); bits [9:0] are VPN0.
- `PTE_W`, 64: stored PTE width.
- `ASID_W`, 9: ASID width.
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `cs` in 1: access strobe.
- `we` in 1: 1 = refill write, 0 = lookup.
- `vpn` in VPN_W: virtual page number.
- `asid` in ASID_W: current ASID (satp.ASID).
- `spage` in 1: refill is a 4 MiB superpage.
- `global_in` in 1: refill PTE.G.
- `pte_in` in PTE_W: refill PTE.
- `pte_hit` out 1: lookup hit.
- `pte_out` out PTE_W: hit PTE; for superpages, VPN0 is merged into bits [19:10].
- `busy` out 1: sweep flush in progress.
- `tlb_flush_req` in 1: flush request pulse.
- `tlb_flush_all_vaddr` in 1: rs1 = x0.
- `tlb_flush_all_asid` in 1: rs2 = x0.
- `tlb_flush_vaddr` in XLEN: flush virtual address; the VPN is [31:12].
- `tlb_flush_asid` in XLEN: flush ASID; the low ASID_W bits are used.

## Operation
- Index: `idx = vpn[10 +: log2(SETS)]`.
- Tag: the remaining upper VPN bits plus VPN0. VPN0 is zeroed when an entry or refill is a superpage.
- Per-entry state:
  - valid, spg, global, asid, tag, pte (flop arrays);
  - LRU age of log2(WAYS) bits.
- Hit condition, per way: `valid && tag match (VPN0 masked if spg) && (global || asid == entry.asid)`.
- Multiple hits are illegal. If they occur, the lowest-index way drives `pte_out`.
- Refill (`cs && we`) selects the target way in this order:
  1. a way already matching tag and ASID in that set (prevents duplicates);
  2. else the lowest-index invalid way;
  3. else the way with age == WAYS-1.
- LRU update on refill or lookup hit:
  - the touched way's age becomes 0;
  - ways with age lower than the touched way's old age increment;
  - other ways are unchanged.
- A lookup miss leaves ages unchanged.
- Reset ages: way g = g. Ages remain a permutation at all times.
- Flush, sampled when `tlb_flush_req` is high and the FSM is IDLE:
  - **all_vaddr && all_asid**: clear every valid bit at the next edge. Single cycle; `busy` stays 0.
  - **vaddr specific**: in set idx(flush VPN), clear ways whose tag matches (superpage-aware) and which satisfy `all_asid || (!global && asid == flush_asid)`. Single cycle.
  - **all_vaddr only**: enter SWEEP. Clear non-global entries with `asid == flush_asid`, one set per cycle, sets 0..SETS-1.
- Ages are never modified by a flush.
- FSM:
  - IDLE→SWEEP on an ASID-only flush; the set pointer is loaded with 0.
  - In SWEEP the pointer increments each cycle.
  - SWEEP→IDLE after processing set SETS-1.
- While busy:
  - lookups return `pte_hit`=0;
  - writes are dropped;
  - `tlb_flush_req` is ignored.
- `cs` in the same cycle as an accepted flush: the flush wins, the write is dropped and the lookup misses.

## Timing
- Reset values: `pte_hit`=0, `pte_out`=0, `busy`=0, FSM IDLE, all valid=0.
- Lookup latency is 1 cycle: `cs && !we` at edge N gives `pte_hit`/`pte_out` valid after edge N+1.
- Outputs hold until the next lookup; a write does not disturb them.
- A refill at edge N is visible to a lookup issued at edge N+1.
- A flush accepted at edge N: entries are invalid for lookups issued from N+1. For a sweep, entries are invalid once `busy` falls.
- `busy` is high for exactly SETS cycles after an ASID-only flush.
- `rstn` low mid-sweep aborts the sweep immediately and clears all state.

## Configuration
- `TLB_ASID_EN` defined: behaviour as above.
- `TLB_ASID_EN` undefined:
  - ASID storage and compare are removed;
  - every valid entry matches regardless of `asid`;
  - any flush with `!tlb_flush_all_vaddr` is a vaddr flush across all ASIDs;
  - any flush with `tlb_flush_all_vaddr` is a single-cycle flush-all;
  - SWEEP is never entered and `busy` is tied to 0.

## Test plan
- Refill VPN 0x12345, ASID 3, PTE 0xABCD → lookup VPN 0x12345, ASID 3: `pte_hit`=1, `pte_out`=0xABCD. Same lookup with ASID 4: `pte_hit`=0.
- Superpage refill VPN 0x12000 with spage=1, PTE 0x2000_0000 → lookup VPN 0x12155: hit, `pte_out`=0x2000_0000 | (0x155<<10).
- Fill 5 distinct tags into one set (WAYS=4), touching the first tag in between → the second-written tag is evicted and the other four hit.
- ASID-only flush of ASID 3 with global and ASID-5 entries present → `busy` is high for 32 cycles and lookups miss meanwhile. Afterwards ASID-3 entries miss, while global and ASID-5 entries hit.
- Vaddr flush 0x12345000 with all_asid → only that VPN misses, and a neighbour in the same set still hits. Flush and refill in the same cycle → the refill entry is absent.
- Assert `rstn` at sweep cycle 10 → `busy`=0 and `pte_hit`=0 immediately, all entries miss, and ages reset to way index.
